// File: rtl/char_stream_arb.sv
// char_stream_arb
//   Shares the single ASCII write port of the VGA character buffer among
//   p_num_reqs byte producers. Arbitration is round-robin. Once a requester
//   wins with a byte that does not end a line, it keeps the port until it
//   sends LF (0x0A) or ESC (0x1B), so lines from different producers never
//   interleave. The output stream has no backpressure.
//
// Optional feature (compile-time macro CHAR_ARB_TIMEOUT_EN):
//   A line owner that stalls for p_timeout cycles loses its lock. When this
//   happens, timeout pulses for one cycle. Without the macro, timeout is tied
//   to 0 and a lock is held until LF or ESC.
//
// Parameters
//   p_num_reqs  number of requesters (>= 2)
//   p_timeout   idle cycles before a stalled owner is released (macro only)
//
// Ports
//   clk        clock; all state updates on posedge
//   rst        synchronous, active-high reset
//   req_ascii  byte from requester i at bits [8i+7:8i]
//   req_val    requester i has a valid byte
//   req_rdy    byte of requester i is accepted this cycle (one-hot or zero)
//   ascii      registered byte to the character buffer
//   ascii_val  ascii is valid this cycle
//   locked     a line owner currently holds the port
//   owner      current or last owner index
//   timeout    one-cycle pulse on forced lock release
module char_stream_arb #(
  parameter int p_num_reqs = 4,
  parameter int p_timeout  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*p_num_reqs-1:0]       req_ascii,
  input  logic [p_num_reqs-1:0]         req_val,
  output logic [p_num_reqs-1:0]         req_rdy,
  output logic [7:0]                    ascii,
  output logic                          ascii_val,
  output logic                          locked,
  output logic [$clog2(p_num_reqs)-1:0] owner,
  output logic                          timeout
);

  localparam int IW = $clog2(p_num_reqs);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   ptr_reg;
  logic [7:0]      ascii_reg;
  logic            ascii_val_reg;

  // Byte lanes split out per requester.
  logic [7:0] req_byte [p_num_reqs];
  for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_lane
    assign req_byte[gi] = req_ascii[8*gi +: 8];
  end

  // Successor index modulo p_num_reqs. N need not be a power of 2, so the
  // wrap is explicit.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == p_num_reqs - 1) return '0;
    else                           return i + IW'(1);
  endfunction

  // Round-robin search starting at ptr_reg. This is used only while IDLE.
  logic          grant_found;
  logic [IW-1:0] grant_idx;
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx = (int'(ptr_reg) + k) % p_num_reqs;
      if (!grant_found && req_val[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  // The selected requester and the transfer flag. While LOCKED only the
  // owner is eligible. rdy is built from val and state only, never from itself.
  logic [IW-1:0] sel_idx;
  logic          xfer;
  logic [7:0]    sel_byte;
  logic          sel_eol;
  always_comb begin
    sel_idx = '0;
    xfer    = 1'b0;
    req_rdy = '0;
    if (state_reg == ST_LOCKED) begin
      sel_idx = owner_reg;
      xfer    = req_val[owner_reg];
    end else begin
      sel_idx = grant_idx;
      xfer    = grant_found;
    end
    if (xfer) req_rdy[sel_idx] = 1'b1;
  end

  assign sel_byte = req_byte[sel_idx];
  assign sel_eol  = (sel_byte == 8'h0A) || (sel_byte == 8'h1B);

`ifdef CHAR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(p_timeout + 1);
  logic [CW-1:0] idle_cnt_reg;
  logic          timeout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      ascii_reg     <= '0;
      ascii_val_reg <= 1'b0;
      idle_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      ascii_val_reg <= xfer;
      if (xfer) ascii_reg <= sel_byte;
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (xfer) begin
            owner_reg <= sel_idx;
            if (sel_eol) begin
              ptr_reg <= next_idx(sel_idx);
            end else begin
              state_reg    <= ST_LOCKED;
              idle_cnt_reg <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (xfer) begin
            idle_cnt_reg <= '0;
            if (sel_eol) begin
              state_reg <= ST_IDLE;
              ptr_reg   <= next_idx(owner_reg);
            end
          end else if (idle_cnt_reg == CW'(p_timeout - 1)) begin
            // The counter reaches p_timeout on this edge. Release now so
            // that the pulse and IDLE appear together in the next cycle.
            state_reg    <= ST_IDLE;
            ptr_reg      <= next_idx(owner_reg);
            timeout_reg  <= 1'b1;
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign timeout = timeout_reg;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      ascii_reg     <= '0;
      ascii_val_reg <= 1'b0;
    end else begin
      ascii_val_reg <= xfer;
      if (xfer) ascii_reg <= sel_byte;
      case (state_reg)
        ST_IDLE: begin
          if (xfer) begin
            owner_reg <= sel_idx;
            if (sel_eol) ptr_reg   <= next_idx(sel_idx);
            else         state_reg <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (xfer && sel_eol) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= next_idx(owner_reg);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign ascii     = ascii_reg;
  assign ascii_val = ascii_val_reg;
  assign locked    = (state_reg == ST_LOCKED);
  assign owner     = owner_reg;

endmodule
